// File: rtl/reg_index_encoder_pkg.sv
// Shared constants, FSM state type and a modular-add helper for the register index encoder.
package reg_index_encoder_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // (a + b) mod WIDTH, valid for a < WIDTH and b < WIDTH
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] a,
                                                  input int unsigned b);
        int unsigned s;
        s = 32'(a) + b;
        if (s >= WIDTH) begin
            s = s - WIDTH;
        end
        return IDX_W'(s);
    endfunction

endpackage

// File: rtl/reg_index_encoder_find_first_set.sv
// Combinational search for the first set mask bit at or above i_start, wrapping WIDTH-1 -> 0.
module reg_index_encoder_find_first_set
    import reg_index_encoder_pkg::*;
(
    input  logic [WIDTH-1:0] i_mask,
    input  logic [IDX_W-1:0] i_start,
    output logic [IDX_W-1:0] o_index,
    output logic             o_found
);

    // Scan offsets from farthest to nearest so the nearest set bit wins
    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if (i_mask[wrap_add(i_start, WIDTH - 1 - k)]) begin
                o_index = wrap_add(i_start, WIDTH - 1 - k);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_index_encoder.sv
// Serialises a multi-hot register mask into register indices over a valid/ready stream.
// Optional round-robin start pointer enabled by defining REG_IDX_ROUND_ROBIN_EN.
module reg_index_encoder
    import reg_index_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] vector_i,
    output logic [IDX_W-1:0] index_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] w_mask_nxt;
    logic [WIDTH-1:0] w_mask_left;
    logic [WIDTH-1:0] w_search_mask;
    logic [IDX_W-1:0] r_index;
    logic [IDX_W-1:0] w_index_nxt;
    logic [IDX_W-1:0] w_start;
    logic [IDX_W-1:0] w_ffs_index;
    logic             w_ffs_found;
    logic             r_valid;
    logic             w_valid_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_hs;

    assign w_hs          = (r_state == DRAIN) && r_valid && ready_i;
    assign w_mask_left   = r_mask & ~(WIDTH'(1) << r_index);
    assign w_search_mask = (r_state == IDLE) ? vector_i : w_mask_left;

`ifdef REG_IDX_ROUND_ROBIN_EN
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_index_inc;

    assign w_index_inc = wrap_add(r_index, 1);
    assign w_start     = w_hs ? w_index_inc : r_ptr;

    // Pointer survives loads; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (w_hs) begin
            r_ptr <= w_index_inc;
        end
    end
`else
    assign w_start = '0;
`endif

    reg_index_encoder_find_first_set u_ffs (
        .i_mask  (w_search_mask),
        .i_start (w_start),
        .o_index (w_ffs_index),
        .o_found (w_ffs_found)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_mask  <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mask  <= w_mask_nxt;
            r_index <= w_index_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // w_ffs_found doubles as "mask non-empty" in IDLE and "bits remain" in DRAIN
    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_index_nxt = r_index;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_i) begin
                    if (w_ffs_found) begin
                        w_state_nxt = DRAIN;
                        w_mask_nxt  = vector_i;
                        w_index_nxt = w_ffs_index;
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_hs) begin
                    w_mask_nxt = w_mask_left;
                    if (w_ffs_found) begin
                        w_index_nxt = w_ffs_index;
                    end else begin
                        w_state_nxt = IDLE;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign index_o = r_index;
    assign valid_o = r_valid;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule

// File: tb/tb_reg_index_encoder.sv
// Directed, table-driven bench for reg_index_encoder (priority and round-robin builds).
module tb_reg_index_encoder;
    import reg_index_encoder_pkg::*;

    logic             clk;
    logic             reset;
    logic             load_i;
    logic [WIDTH-1:0] vector_i;
    logic [IDX_W-1:0] index_o;
    logic             valid_o;
    logic             ready_i;
    logic             busy_o;
    logic             done_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0]     vec;
        int              n;
        logic [3:0][4:0] idx;
    } vec_t;

    reg_index_encoder dut (
        .clk      (clk),
        .reset    (reset),
        .load_i   (load_i),
        .vector_i (vector_i),
        .index_o  (index_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .busy_o   (busy_o),
        .done_o   (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] vec, input int n,
                                input logic [4:0] i0, input logic [4:0] i1,
                                input logic [4:0] i2, input logic [4:0] i3);
        vec_t v;
        v.vec    = vec;
        v.n      = n;
        v.idx[0] = i0;
        v.idx[1] = i1;
        v.idx[2] = i2;
        v.idx[3] = i3;
        return v;
    endfunction

    // Load a mask with ready held high and expect back-to-back indices then one done pulse
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        load_i   = 1'b1;
        vector_i = v.vec;
        ready_i  = 1'b1;
        @(negedge clk);
        load_i   = 1'b0;
        for (int k = 0; k < v.n; k++) begin
            check($sformatf("%s valid[%0d]", tag, k), 32'(valid_o), 32'd1);
            check($sformatf("%s busy[%0d]", tag, k), 32'(busy_o), 32'd1);
            check($sformatf("%s index[%0d]", tag, k), 32'(index_o), 32'(v.idx[k]));
            check($sformatf("%s done_early[%0d]", tag, k), 32'(done_o), 32'd0);
            @(negedge clk);
        end
        check({tag, " valid_end"}, 32'(valid_o), 32'd0);
        check({tag, " busy_end"}, 32'(busy_o), 32'd0);
        check({tag, " done_pulse"}, 32'(done_o), 32'd1);
        @(negedge clk);
        check({tag, " done_clear"}, 32'(done_o), 32'd0);
        check({tag, " valid_idle"}, 32'(valid_o), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    vec_t tbl[6];

    initial begin
        reset    = 1'b1;
        load_i   = 1'b0;
        vector_i = '0;
        ready_i  = 1'b0;
        #1 reset = 1'b0;
        #2;
        check("rst valid", 32'(valid_o), 32'd0);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst index", 32'(index_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

`ifndef REG_IDX_ROUND_ROBIN_EN
        tbl[0] = mk(32'h8000_0005, 3, 5'd0,  5'd2,  5'd31, 5'd0);
        tbl[1] = mk(32'h0000_0000, 0, 5'd0,  5'd0,  5'd0,  5'd0);
        tbl[2] = mk(32'h0000_0001, 1, 5'd0,  5'd0,  5'd0,  5'd0);
        tbl[3] = mk(32'h8000_0000, 1, 5'd31, 5'd0,  5'd0,  5'd0);
        tbl[4] = mk(32'h00F0_0000, 4, 5'd20, 5'd21, 5'd22, 5'd23);
        tbl[5] = mk(32'h4000_0200, 2, 5'd9,  5'd30, 5'd0,  5'd0);
        for (int t = 0; t < 6; t++) begin
            run_vec(tbl[t], $sformatf("tbl%0d", t));
        end
`endif

        // Reset asserted mid-drain clears outputs immediately
        @(negedge clk);
        load_i   = 1'b1;
        vector_i = 32'h0000_00F0;
        ready_i  = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        check("mid idx4", 32'(index_o), 32'd4);
        @(negedge clk);
        check("mid idx5", 32'(index_o), 32'd5);
        @(negedge clk);
        check("mid idx6 valid", 32'(valid_o), 32'd1);
        reset = 1'b0;
        #1;
        check("mid rst valid", 32'(valid_o), 32'd0);
        check("mid rst busy", 32'(busy_o), 32'd0);
        check("mid rst done", 32'(done_o), 32'd0);
        check("mid rst index", 32'(index_o), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_vec(mk(32'h0000_0001, 1, 5'd0, 5'd0, 5'd0, 5'd0), "post_rst");

        // Backpressure: index and valid hold while ready is low
        @(negedge clk);
        load_i   = 1'b1;
        vector_i = 32'h0000_0006;
        ready_i  = 1'b0;
        @(negedge clk);
        load_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("stall valid[%0d]", c), 32'(valid_o), 32'd1);
            check($sformatf("stall index[%0d]", c), 32'(index_o), 32'd1);
            @(negedge clk);
        end
        ready_i = 1'b1;
        check("stall rel idx1", 32'(index_o), 32'd1);
        @(negedge clk);
        check("stall rel idx2", 32'(index_o), 32'd2);
        check("stall rel valid", 32'(valid_o), 32'd1);
        @(negedge clk);
        check("stall done", 32'(done_o), 32'd1);
        check("stall valid_end", 32'(valid_o), 32'd0);

        // Loads during drain, including on the final handshake, are ignored
        @(negedge clk);
        load_i   = 1'b1;
        vector_i = 32'h0000_0003;
        ready_i  = 1'b1;
        @(negedge clk);
        vector_i = 32'hFFFF_FFFF;
        check("ign idx0", 32'(index_o), 32'd0);
        @(negedge clk);
        check("ign idx1", 32'(index_o), 32'd1);
        check("ign valid1", 32'(valid_o), 32'd1);
        @(negedge clk);
        load_i = 1'b0;
        check("ign done", 32'(done_o), 32'd1);
        check("ign valid_end", 32'(valid_o), 32'd0);
        @(negedge clk);
        check("ign no_relatch valid", 32'(valid_o), 32'd0);
        check("ign no_relatch busy", 32'(busy_o), 32'd0);

`ifdef REG_IDX_ROUND_ROBIN_EN
        pulse_reset();
        run_vec(mk(32'h8000_0001, 2, 5'd0, 5'd31, 5'd0, 5'd0), "rr_a");
        run_vec(mk(32'h8000_0001, 2, 5'd0, 5'd31, 5'd0, 5'd0), "rr_b");
        run_vec(mk(32'h0000_0010, 1, 5'd4, 5'd0, 5'd0, 5'd0), "rr_ptr5");
        run_vec(mk(32'h0000_0004, 1, 5'd2, 5'd0, 5'd0, 5'd0), "rr_wrap");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
